// File: rtl/bypass_pkg.sv
// Shared types and helpers for the operand bypass network.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   REG_ADDR_W      architectural register index width
//   bypass_entry_t  one tracked in-flight destination write {valid, rd, is_load}
//   is_ready()      whether a tracked entry's result is available on stage_data
package bypass_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } bypass_entry_t;

  // Non-loads produce their result in the stage they sit in; load data only
  // appears on stage_data from load_stage onwards.
  function automatic logic is_ready(input bypass_entry_t e, input int k,
                                    input int load_stage);
    return !e.is_load || (k >= load_stage);
  endfunction

endpackage

// File: rtl/bypass_select.sv
// Per-source operand resolver: youngest-match priority, readiness check, data mux.
// Latency: purely combinational, zero cycles.
// Backpressure: raises stall when the youngest match is a load still in flight.
//
// Ports:
//   entries     in   tracked in-flight writes, index 0 = youngest (EX)
//   rs          in   source register index
//   rf_val      in   register-file read value for rs
//   stage_data  in   DEPTH results, stage k at [k*XLEN +: XLEN]
//   val         out  resolved operand
//   fwd         out  one-hot forwarding stage (zero = regfile)
//   stall       out  youngest match is not ready
module bypass_select
  import bypass_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  bypass_entry_t [DEPTH-1:0]      entries,
  input  logic [REG_ADDR_W-1:0]          rs,
  input  logic [XLEN-1:0]                rf_val,
  input  logic [DEPTH*XLEN-1:0]          stage_data,
  output logic [XLEN-1:0]                val,
  output logic [DEPTH-1:0]               fwd,
  output logic                           stall
);

  logic found;

  always_comb begin
    val   = rf_val;
    fwd   = '0;
    stall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      // Only the first (youngest) match counts; older ones are shadowed even
      // if their data is ready, which keeps WAW ordering correct.
      if (!found && entries[k].valid && (entries[k].rd == rs) && (rs != '0)) begin
        found = 1'b1;
        if (is_ready(entries[k], k, LOAD_STAGE)) begin
          val    = stage_data[k*XLEN +: XLEN];
          fwd[k] = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/operand_bypass_net.sv
// Operand forwarding network with in-flight write tracking and load-use stall.
// Latency: operand select and stall are combinational (zero cycles); tracking updates on clk.
// Backpressure: stall holds the issue stage; a stalled issue enters the pipe as a bubble.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   adv, flush                  shift tracked stages / kill all in-flight entries
//   iss_valid/iss_rd/iss_is_load issuing instruction's destination write
//   src_rs, src_rf_val          NUM_SRC source indices and regfile values
//   stage_data                  DEPTH stage results, stage k at [k*XLEN +: XLEN]
//   src_val, src_fwd            resolved operands and one-hot forward source per operand
//   stall                       load-use hazard on any source
//   stall_cnt                   saturating stalled-cycle count (only with BYPASS_PERF_CNT_EN)
// Build option: define BYPASS_PERF_CNT_EN to add the stall_cnt counter and port.
module operand_bypass_net
  import bypass_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adv,
  input  logic                          flush,
  input  logic                          iss_valid,
  input  logic [REG_ADDR_W-1:0]         iss_rd,
  input  logic                          iss_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rs,
  input  logic [NUM_SRC*XLEN-1:0]       src_rf_val,
  input  logic [DEPTH*XLEN-1:0]         stage_data,
  output logic [NUM_SRC*XLEN-1:0]       src_val,
  output logic [NUM_SRC*DEPTH-1:0]      src_fwd,
  output logic                          stall
`ifdef BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  bypass_entry_t [DEPTH-1:0] entries;
  logic [NUM_SRC-1:0]        src_stall;

  // Entry shift register. flush wins over adv; without adv everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (flush) begin
      entries <= '0;
    end else if (adv) begin
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
      // A stalled issue must not be tracked: it enters as a bubble.
      entries[0].valid   <= iss_valid & ~stall;
      entries[0].rd      <= iss_rd;
      entries[0].is_load <= iss_is_load;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    bypass_select #(
      .XLEN       (XLEN),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_sel (
      .entries    (entries),
      .rs         (src_rs[s*REG_ADDR_W +: REG_ADDR_W]),
      .rf_val     (src_rf_val[s*XLEN +: XLEN]),
      .stage_data (stage_data),
      .val        (src_val[s*XLEN +: XLEN]),
      .fwd        (src_fwd[s*DEPTH +: DEPTH]),
      .stall      (src_stall[s])
    );
  end

  assign stall = |src_stall;

`ifdef BYPASS_PERF_CNT_EN
  // Stalled cycles that are being flushed away are not counted; flush does
  // not clear the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_net.sv
// Directed table-driven bench for operand_bypass_net (XLEN=64, NUM_SRC=2, DEPTH=3, LOAD_STAGE=1).
// Each table row is one clock cycle: inputs are driven after the falling edge,
// outputs are checked 1ns later, and the rising edge then updates the tracker.
module tb_operand_bypass_net;

  localparam int XLEN = 64;
  localparam int NS   = 2;
  localparam int DP   = 3;
  localparam logic [63:0] RF0 = 64'hA;
  localparam logic [63:0] RF1 = 64'hB;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 adv, flush, iss_valid, iss_is_load;
  logic [4:0]           iss_rd;
  logic [NS*5-1:0]      src_rs;
  logic [NS*XLEN-1:0]   src_rf_val;
  logic [DP*XLEN-1:0]   stage_data;
  logic [NS*XLEN-1:0]   src_val;
  logic [NS*DP-1:0]     src_fwd;
  logic                 stall;
`ifdef BYPASS_PERF_CNT_EN
  logic [31:0]          stall_cnt;
  int                   exp_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_bypass_net #(.XLEN(XLEN), .NUM_SRC(NS), .DEPTH(DP), .LOAD_STAGE(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adv         (adv),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_is_load (iss_is_load),
    .src_rs      (src_rs),
    .src_rf_val  (src_rf_val),
    .stage_data  (stage_data),
    .src_val     (src_val),
    .src_fwd     (src_fwd),
    .stall       (stall)
`ifdef BYPASS_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic        adv, flush, iv, il;
    logic [4:0]  ird, rs0, rs1;
    logic [63:0] sd0, sd1, sd2;
    logic [63:0] v0, v1;
    logic [2:0]  f0, f1;
    logic        st;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic a, input logic fl, input logic iv,
                              input logic [4:0] ird, input logic il,
                              input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [63:0] sd0, input logic [63:0] sd1,
                              input logic [63:0] sd2,
                              input logic [63:0] v0, input logic [2:0] f0,
                              input logic [63:0] v1, input logic [2:0] f1,
                              input logic st);
    vec_t r;
    r.adv = a;   r.flush = fl; r.iv = iv; r.ird = ird; r.il = il;
    r.rs0 = rs0; r.rs1 = rs1;
    r.sd0 = sd0; r.sd1 = sd1; r.sd2 = sd2;
    r.v0 = v0;   r.f0 = f0;   r.v1 = v1; r.f1 = f1; r.st = st;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    adv         = v.adv;
    flush       = v.flush;
    iss_valid   = v.iv;
    iss_rd      = v.ird;
    iss_is_load = v.il;
    src_rs      = {v.rs1, v.rs0};
    stage_data  = {v.sd2, v.sd1, v.sd0};
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk("val0",  i, src_val[63:0],   v.v0);
    chk("val1",  i, src_val[127:64], v.v1);
    chk("fwd0",  i, {61'd0, src_fwd[2:0]}, {61'd0, v.f0});
    chk("fwd1",  i, {61'd0, src_fwd[5:3]}, {61'd0, v.f1});
    chk("stall", i, {63'd0, stall},  {63'd0, v.st});
  endtask

  initial begin
    logic [63:0] D0, D1, D2;
    D0 = 64'h100; D1 = 64'h200; D2 = 64'h300;

    //            adv fl iv ird il rs0 rs1 sd0      sd1         sd2     v0        f0  v1          f1  st
    vt[0]  = mk(0, 0, 0, 0, 0, 1, 2, D0,      D1,         D2,     RF0,      0, RF1,        0, 0); // reset state
    vt[1]  = mk(1, 0, 1, 5, 0, 1, 2, D0,      D1,         D2,     RF0,      0, RF1,        0, 0); // issue rd5
    vt[2]  = mk(0, 0, 0, 0, 0, 5, 2, 64'h1234, D1,        D2,     64'h1234, 1, RF1,        0, 0); // fwd from EX
    vt[3]  = mk(1, 0, 1, 7, 1, 5, 2, 64'h1234, D1,        D2,     64'h1234, 1, RF1,        0, 0); // issue load rd7
    vt[4]  = mk(0, 0, 0, 0, 0, 5, 7, D0,      D1,         D2,     D1,       2, RF1,        0, 1); // load-use stall
    vt[5]  = mk(1, 0, 1, 9, 0, 5, 7, D0,      D1,         D2,     D1,       2, RF1,        0, 1); // stalled issue -> bubble
    vt[6]  = mk(0, 0, 0, 0, 0, 9, 7, D0,      64'hBEEF,   D2,     RF0,      0, 64'hBEEF,   2, 0); // load now in MEM; rd9 absent
    vt[7]  = mk(1, 0, 1, 3, 0, 9, 7, D0,      64'hBEEF,   D2,     RF0,      0, 64'hBEEF,   2, 0); // issue rd3
    vt[8]  = mk(1, 0, 1, 4, 0, 3, 7, D0,      D1,         D2,     D0,       1, D2,         4, 0); // load in WB ready
    vt[9]  = mk(1, 0, 1, 3, 0, 3, 4, D0,      D1,         D2,     D1,       2, D0,         1, 0); // issue rd3 again
    vt[10] = mk(0, 0, 0, 0, 0, 3, 3, 64'h11,  D1,         64'h33, 64'h11,   1, 64'h11,     1, 0); // youngest of duplicates
    vt[11] = mk(1, 0, 1, 0, 0, 0, 3, D0,      D1,         D2,     RF0,      0, D0,         1, 0); // issue rd0
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, D0,      D1,         D2,     RF0,      0, RF1,        0, 0); // x0 never forwards
    vt[13] = mk(0, 0, 1, 8, 0, 8, 3, D0,      D1,         D2,     RF0,      0, D1,         2, 0); // no adv: hold
    vt[14] = mk(0, 0, 0, 0, 0, 8, 3, D0,      D1,         D2,     RF0,      0, D1,         2, 0); // rd8 not inserted
    vt[15] = mk(1, 0, 1, 6, 1, 8, 3, D0,      D1,         D2,     RF0,      0, D1,         2, 0); // issue load rd6
    vt[16] = mk(1, 1, 0, 0, 0, 6, 3, D0,      D1,         D2,     RF0,      0, D2,         4, 1); // stall + flush&adv
    vt[17] = mk(0, 0, 0, 0, 0, 6, 3, D0,      D1,         D2,     RF0,      0, RF1,        0, 0); // all flushed

    src_rf_val = {RF1, RF0};
    rst_n = 1'b0;
    drive(vt[0]);
`ifdef BYPASS_PERF_CNT_EN
    exp_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check_row(i, vt[i]);
`ifdef BYPASS_PERF_CNT_EN
      chk("stall_cnt", i, {32'd0, stall_cnt}, exp_cnt);
      if (vt[i].st && !vt[i].flush) exp_cnt++;
`endif
    end

    // Asynchronous reset between clock edges while a load-use stall is pending.
    @(negedge clk);
    drive(mk(1, 0, 1, 10, 1, 1, 2, D0, D1, D2, RF0, 0, RF1, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 10, 2, D0, D1, D2, RF0, 0, RF1, 0, 1));
    #1;
    chk("pre_rst_stall", 0, {63'd0, stall}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 0, {63'd0, stall}, 64'd0);
    chk("rst_fwd",   0, {58'd0, src_fwd}, 64'd0);
    chk("rst_val0",  0, src_val[63:0], RF0);
`ifdef BYPASS_PERF_CNT_EN
    chk("rst_cnt",   0, {32'd0, stall_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", 0, {63'd0, stall}, 64'd0);
    chk("post_rst_val0",  0, src_val[63:0], RF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
